// File: rtl/huffman_dc_dpcm_enc.sv
// JPEG DC DPCM encoder: per-component prediction and saturation in S1, then
// category, DC Huffman lookup and magnitude bits in S2.
module huffman_dc_dpcm_enc #(
  parameter int unsigned COEF_W   = 11,
  parameter int unsigned NUM_COMP = 3,
  parameter int unsigned CID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_dc,
  input  logic [CID_W-1:0]         in_comp,
  input  logic                     in_restart,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [10:0]              huff_code,
  output logic [3:0]               huff_len,
  output logic [10:0]              mag_bits,
  output logic [3:0]               mag_len,
  output logic                     sat
);
  localparam int unsigned DW = COEF_W + 1;

  logic signed [COEF_W-1:0] pred_q [NUM_COMP];
  logic signed [COEF_W-1:0] pred_d [NUM_COMP];
  logic signed [COEF_W-1:0] pred_sel;
  logic signed [DW-1:0]     diff_full;
  logic signed [31:0]       diff_ext;
  logic                     comp_ok;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_sat_q, s1_sat_d;
  logic              s1_luma_q, s1_luma_d;
  logic signed [11:0] s1_diff_q, s1_diff_d;

  logic        out_valid_q, out_valid_d;
  logic        sat_q, sat_d;
  logic [10:0] huff_code_q, huff_code_d;
  logic [10:0] mag_bits_q, mag_bits_d;
  logic [3:0]  huff_len_q, huff_len_d;
  logic [3:0]  mag_len_q, mag_len_d;

  logic        s2_load, accept;
  logic [11:0] abs_v, mval, mask;
  logic [3:0]  cat, code_len;
  logic [10:0] code_v;

  assign s2_load  = !out_valid_q || out_ready;
  assign in_ready = !rst && (!s1_valid_q || s2_load);
  assign accept   = in_valid && in_ready;

  // Out-of-range component ids fall back to predictor 0 and update nothing.
  always_comb begin
    comp_ok  = 1'b0;
    pred_sel = pred_q[0];
    for (int i = 0; i < NUM_COMP; i++) begin
      if (in_comp == CID_W'(i)) begin
        comp_ok  = 1'b1;
        pred_sel = pred_q[i];
      end
    end
    if (in_restart) pred_sel = '0;
    diff_full = DW'(in_dc) - DW'(pred_sel);
    diff_ext  = 32'(diff_full);

    s1_valid_d = accept ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
    s1_sat_d   = s1_sat_q;
    s1_diff_d  = s1_diff_q;
    s1_luma_d  = s1_luma_q;
    if (accept) begin
      s1_luma_d = (in_comp == '0) || !comp_ok;
      s1_sat_d  = 1'b0;
      s1_diff_d = 12'(diff_ext);
      if (diff_ext > 32'sd2047) begin
        s1_diff_d = 12'sd2047;
        s1_sat_d  = 1'b1;
      end else if (diff_ext < -32'sd2047) begin
        s1_diff_d = -12'sd2047;
        s1_sat_d  = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_COMP; i++) pred_d[i] = pred_q[i];
    if (accept) begin
      if (in_restart) begin
        for (int i = 0; i < NUM_COMP; i++) pred_d[i] = '0;
      end
      for (int i = 0; i < NUM_COMP; i++) begin
        if (in_comp == CID_W'(i)) pred_d[i] = in_dc;
      end
    end
  end

  always_comb begin
    abs_v = s1_diff_q[11] ? 12'(-s1_diff_q) : 12'(s1_diff_q);
    cat   = '0;
    for (int i = 0; i < 12; i++) begin
      if (abs_v[i]) cat = 4'(i + 1);
    end
    // Negative differences carry the one's-complement of |diff|.
    mval = s1_diff_q[11] ? 12'(s1_diff_q - 12'sd1) : 12'(s1_diff_q);
    mask = (12'd1 << cat) - 12'd1;

    // Long codes are (len-1) ones followed by a zero.
    if (s1_luma_q) begin
      code_len = (cat == 4'd0) ? 4'd2 : ((cat <= 4'd5) ? 4'd3 : cat - 4'd2);
      code_v   = (cat == 4'd0) ? 11'd0 : 11'(cat + 4'd1);
      if (cat > 4'd5) code_v = 11'((12'd1 << code_len) - 12'd2);
    end else begin
      code_len = (cat <= 4'd2) ? 4'd2 : cat;
      code_v   = 11'(cat);
      if (cat > 4'd2) code_v = 11'((12'd1 << code_len) - 12'd2);
    end

    out_valid_d = out_valid_q;
    huff_code_d = huff_code_q;
    huff_len_d  = huff_len_q;
    mag_bits_d  = mag_bits_q;
    mag_len_d   = mag_len_q;
    sat_d       = sat_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        huff_code_d = code_v;
        huff_len_d  = code_len;
        mag_bits_d  = 11'(mval & mask);
        mag_len_d   = cat;
        sat_d       = s1_sat_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_COMP; i++) pred_q[i] <= '0;
      s1_valid_q  <= 1'b0;
      s1_sat_q    <= 1'b0;
      s1_luma_q   <= 1'b0;
      s1_diff_q   <= '0;
      out_valid_q <= 1'b0;
      huff_code_q <= '0;
      huff_len_q  <= '0;
      mag_bits_q  <= '0;
      mag_len_q   <= '0;
      sat_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_COMP; i++) pred_q[i] <= pred_d[i];
      s1_valid_q  <= s1_valid_d;
      s1_sat_q    <= s1_sat_d;
      s1_luma_q   <= s1_luma_d;
      s1_diff_q   <= s1_diff_d;
      out_valid_q <= out_valid_d;
      huff_code_q <= huff_code_d;
      huff_len_q  <= huff_len_d;
      mag_bits_q  <= mag_bits_d;
      mag_len_q   <= mag_len_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q && !rst;
  assign huff_code = huff_code_q;
  assign huff_len  = huff_len_q;
  assign mag_bits  = mag_bits_q;
  assign mag_len   = mag_len_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_huffman_dc_dpcm_enc.sv
// Scoreboard bench for huffman_dc_dpcm_enc (COEF_W=12 so saturation is reachable).
module tb_huffman_dc_dpcm_enc;
  logic               clk, rst, in_valid, in_ready, in_restart;
  logic               out_valid, out_ready, sat;
  logic signed [11:0] in_dc;
  logic [1:0]         in_comp;
  logic [10:0]        huff_code, mag_bits;
  logic [3:0]         huff_len, mag_len;

  int checks = 0;
  int errors = 0;
  int nbeat  = 0;
  int npush  = 0;
  int acc_cnt = 0;
  logic [30:0] q[$];

  huffman_dc_dpcm_enc #(.COEF_W(12), .NUM_COMP(3), .CID_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_dc(in_dc),
    .in_comp(in_comp), .in_restart(in_restart), .out_valid(out_valid), .out_ready(out_ready),
    .huff_code(huff_code), .huff_len(huff_len), .mag_bits(mag_bits), .mag_len(mag_len),
    .sat(sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented beat is compared against the head of the queue,
  // including stalled cycles, so held outputs must stay at the expected value.
  initial begin
    logic [30:0] act;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        act = {huff_code, huff_len, mag_bits, mag_len, sat};
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got code=%h len=%0d with empty queue",
                   huff_code, huff_len);
        end else begin
          if (act !== q[0]) begin
            errors++;
            $display("FAIL beat%0d: got code=%h len=%0d mag=%h mlen=%0d sat=%0b expected %h",
                     nbeat, huff_code, huff_len, mag_bits, mag_len, sat, q[0]);
          end
          if (out_ready) begin
            void'(q.pop_front());
            nbeat++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one beat and leaves in_valid high; returns at posedge+1 after acceptance.
  task automatic send(input logic [1:0] comp, input int dc, input logic rs,
                      input logic [10:0] code, input logic [3:0] len,
                      input logic [10:0] mag, input logic [3:0] mlen, input logic s,
                      input bit need_ready);
    bit done = 1'b0;
    in_valid   = 1'b1;
    in_comp    = comp;
    in_dc      = 12'(dc);
    in_restart = rs;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (need_ready && i == 0) chk("ready_streaming", 32'(in_ready), 32'd1);
      if (in_ready) begin
        q.push_back({code, len, mag, mlen, s});
        npush++;
        acc_cnt++;
        done = 1'b1;
      end
      step();
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_restart = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    idle();
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 32'(q.size()), 32'd0);
    step();
  endtask

  initial begin
    int base;
    rst = 1'b1;
    in_valid = 1'b0;
    in_restart = 1'b0;
    in_dc = '0;
    in_comp = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_huff_code", 32'(huff_code), 32'd0);
    chk("rst_huff_len", 32'(huff_len), 32'd0);
    chk("rst_mag_bits", 32'(mag_bits), 32'd0);
    chk("rst_mag_len", 32'(mag_len), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 32'd1);
    step();

    // Basic luma pair, with two-cycle latency on the first beat.
    send(2'd0, 5, 1'b0, 11'h004, 4'd3, 11'h005, 4'd3, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("latency_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_cycle2", 32'(out_valid), 32'd1);
    step();
    send(2'd0, 2, 1'b0, 11'h003, 4'd3, 11'h000, 4'd2, 1'b0, 1'b0);
    // Chroma -1 then zero difference.
    send(2'd1, -1, 1'b0, 11'h001, 4'd2, 11'h000, 4'd1, 1'b0, 1'b1);
    send(2'd1, -1, 1'b0, 11'h000, 4'd2, 11'h000, 4'd0, 1'b0, 1'b1);
    // Interleaved components, restart on the first beat.
    send(2'd0, 10, 1'b1, 11'h005, 4'd3, 11'h00a, 4'd4, 1'b0, 1'b1);
    send(2'd1, 3, 1'b0, 11'h002, 4'd2, 11'h003, 4'd2, 1'b0, 1'b1);
    send(2'd0, 10, 1'b0, 11'h000, 4'd2, 11'h000, 4'd0, 1'b0, 1'b1);
    // Extremes and saturation.
    send(2'd0, 2047, 1'b1, 11'h1fe, 4'd9, 11'h7ff, 4'd11, 1'b0, 1'b1);
    send(2'd0, -2048, 1'b0, 11'h1fe, 4'd9, 11'h000, 4'd11, 1'b1, 1'b1);
    send(2'd2, -2048, 1'b0, 11'h7fe, 4'd11, 11'h000, 4'd11, 1'b1, 1'b1);
    send(2'd2, 2047, 1'b0, 11'h7fe, 4'd11, 11'h7ff, 4'd11, 1'b1, 1'b1);
    send(2'd1, -2047, 1'b0, 11'h7fe, 4'd11, 11'h000, 4'd11, 1'b0, 1'b1);
    // Out-of-range component uses predictor 0 and leaves predictors alone.
    send(2'd3, -2048, 1'b0, 11'h000, 4'd2, 11'h000, 4'd0, 1'b0, 1'b1);
    send(2'd1, -2047, 1'b0, 11'h000, 4'd2, 11'h000, 4'd0, 1'b0, 1'b1);
    send(2'd0, -2040, 1'b0, 11'h005, 4'd3, 11'h008, 4'd4, 1'b0, 1'b1);
    drain();

    // Backpressure with in_valid held high.
    base = acc_cnt;
    out_ready = 1'b0;
    fork
      begin
        send(2'd0, 1, 1'b1, 11'h002, 4'd3, 11'h001, 4'd1, 1'b0, 1'b0);
        send(2'd0, 3, 1'b0, 11'h003, 4'd3, 11'h002, 4'd2, 1'b0, 1'b0);
        send(2'd0, -1, 1'b0, 11'h004, 4'd3, 11'h003, 4'd3, 1'b0, 1'b0);
        send(2'd1, 6, 1'b0, 11'h006, 4'd3, 11'h006, 4'd3, 1'b0, 1'b0);
        idle();
      end
      begin
        repeat (6) @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_accepted", 32'(acc_cnt - base), 32'd2);
        step();
        out_ready = 1'b1;
      end
    join
    drain();

    // Restart forces a zero prediction.
    send(2'd0, 7, 1'b1, 11'h004, 4'd3, 11'h007, 4'd3, 1'b0, 1'b0);
    send(2'd0, 7, 1'b1, 11'h004, 4'd3, 11'h007, 4'd3, 1'b0, 1'b1);
    drain();

    // Mid-stream reset discards in-flight beats and clears predictors.
    send(2'd1, 100, 1'b0, 11'h07e, 4'd7, 11'h064, 4'd7, 1'b0, 1'b0);
    send(2'd2, 50, 1'b0, 11'h03e, 4'd6, 11'h032, 4'd6, 1'b0, 1'b1);
    rst = 1'b1;
    idle();
    npush -= q.size();
    q.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    step();
    @(negedge clk);
    chk("midrst_out_valid2", 32'(out_valid), 32'd0);
    step();
    rst = 1'b0;
    send(2'd1, 100, 1'b0, 11'h07e, 4'd7, 11'h064, 4'd7, 1'b0, 1'b0);
    send(2'd2, 50, 1'b0, 11'h03e, 4'd6, 11'h032, 4'd6, 1'b0, 1'b1);
    send(2'd0, -5, 1'b0, 11'h004, 4'd3, 11'h002, 4'd3, 1'b0, 1'b1);
    drain();
    repeat (3) step();

    chk("all_delivered", 32'(nbeat), 32'(npush));
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
